// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the five-stage pipeline controller: reset level, stall
// vector layout, FSM state encoding and SRAM ownership.
package pipe_ctrl_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    // Bit positions inside stall_o
    localparam int STALL_BIT_PC  = 0;
    localparam int STALL_BIT_IF  = 1;
    localparam int STALL_BIT_ID  = 2;
    localparam int STALL_BIT_EX  = 3;
    localparam int STALL_BIT_MEM = 4;
    localparam int STALL_BIT_WB  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_MEMW = 6'b011111;
    localparam logic [5:0] STALL_MEMD = 6'b001111;

    typedef enum logic {
        CTRL_RUN    = 1'b0,
        CTRL_MEMACC = 1'b1
    } ctrl_state_e;

    localparam logic SRAM_OWN_IF  = 1'b0;
    localparam logic SRAM_OWN_MEM = 1'b1;

    // Width of the MEM access down-counter; covers MEM_LAT up to 15.
    localparam int LAT_CNT_W = 4;

    // Down-counter load value so that the access spans exactly lat cycles:
    // one request cycle in RUN, then lat-1 cycles in MEM_ACC ending at zero.
    function automatic logic [LAT_CNT_W-1:0] lat_init(input int lat);
        if (lat > 1)
            return LAT_CNT_W'(lat - 2);
        else
            return '0;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges load-use stalls, multi-cycle SRAM accesses and
// branch/flush redirects into a per-stage stall vector, flush strobe and PC load.
//
// state       | meaning
// ------------+----------------------------------------------------------
// CTRL_RUN    | normal flow; IF owns SRAM, flush/access/stall/branch arbitration
// CTRL_MEMACC | MEM owns SRAM; down-counter runs until the access completes
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req_i,
    input  logic             stallreq_id_i,
    input  logic             branch_flag_i,
    input  logic [15:0]      branch_addr_i,
    input  logic             flush_req_i,
    input  logic [15:0]      flush_addr_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             pc_load_o,
    output logic [15:0]      pc_target_o,
    output logic             sram_owner_o,
    output logic             mem_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_init(MEM_LAT);

    ctrl_state_e          r_state;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic                 r_flush_pend;
    logic [15:0]          r_pend_addr;

    ctrl_state_e          w_state_nxt;
    logic [LAT_CNT_W-1:0] w_cnt_nxt;
    logic [5:0]           w_stall;
    logic                 w_flush;
    logic                 w_pc_load;
    logic [15:0]          w_pc_target;
    logic                 w_sram_owner;
    logic                 w_mem_done;
    logic                 w_cnt_clr;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall      = STALL_NONE;
        w_flush      = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_target  = 16'h0000;
        w_sram_owner = SRAM_OWN_IF;
        w_mem_done   = 1'b0;

        if (rst != RST_ENABLE) begin
            case (r_state)
                CTRL_RUN: begin
                    // A pending refetch wins over everything; the MEM slot is a bubble then.
                    if (r_flush_pend) begin
                        w_flush     = 1'b1;
                        w_pc_load   = 1'b1;
                        w_pc_target = r_pend_addr;
                    end else if (mem_req_i) begin
                        w_sram_owner = SRAM_OWN_MEM;
                        if (MEM_LAT == 1) begin
                            w_stall    = STALL_MEMD;
                            w_mem_done = 1'b1;
                        end else begin
                            w_stall     = STALL_MEMW;
                            w_cnt_nxt   = LAT_INIT;
                            w_state_nxt = CTRL_MEMACC;
                        end
                    end else if (stallreq_id_i) begin
                        w_stall = STALL_ID;
                    end else if (branch_flag_i) begin
                        w_pc_load   = 1'b1;
                        w_pc_target = branch_addr_i;
                    end
                end
                CTRL_MEMACC: begin
                    w_sram_owner = SRAM_OWN_MEM;
                    if (r_cnt != '0) begin
                        w_stall   = STALL_MEMW;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_stall     = STALL_MEMD;
                        w_mem_done  = 1'b1;
                        w_state_nxt = CTRL_RUN;
                    end
                end
                default: begin
                    w_state_nxt = CTRL_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state      <= CTRL_RUN;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_pend_addr  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Capture on the done cycle only: the store has finished writing by then.
            if (w_mem_done && flush_req_i) begin
                r_flush_pend <= 1'b1;
                r_pend_addr  <= flush_addr_i;
            end else if (w_flush) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    assign w_cnt_clr = (rst == RST_ENABLE);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .i_clr (w_cnt_clr),
        .i_en  (w_stall[STALL_BIT_PC]),
        .o_cnt (stall_cnt_o)
    );

    assign stall_o      = w_stall;
    assign flush_o      = w_flush;
    assign pc_load_o    = w_pc_load;
    assign pc_target_o  = w_pc_target;
    assign sram_owner_o = w_sram_owner;
    assign mem_done_o   = w_mem_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (MEM_LAT=3/16-bit counter and
// MEM_LAT=1/4-bit counter) share stimulus and are checked against a cycle model.
module tb_pipe_ctrl;

    localparam int LAT_A = 3;
    localparam int CW_A  = 16;
    localparam int LAT_B = 1;
    localparam int CW_B  = 4;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        stallreq_id;
    logic        branch_flag;
    logic [15:0] branch_addr;
    logic        flush_req;
    logic [15:0] flush_addr;

    logic [5:0]      a_stall, b_stall;
    logic            a_flush, b_flush;
    logic            a_pcl, b_pcl;
    logic [15:0]     a_tgt, b_tgt;
    logic            a_own, b_own;
    logic            a_done, b_done;
    logic [CW_A-1:0] a_cnt;
    logic [CW_B-1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          rem;    // access cycles still to go, 0 = no access in flight
        bit          fp;
        logic [15:0] pa;
        int          cnt;
    } mst_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        pcl;
        logic [15:0] tgt;
        logic        own;
        logic        done;
        int          cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    mst_t sa, sb;

    pipe_ctrl #(.MEM_LAT(LAT_A), .CNT_W(CW_A)) u_dut_a (
        .clk(clk), .rst(rst), .mem_req_i(mem_req), .stallreq_id_i(stallreq_id),
        .branch_flag_i(branch_flag), .branch_addr_i(branch_addr),
        .flush_req_i(flush_req), .flush_addr_i(flush_addr),
        .stall_o(a_stall), .flush_o(a_flush), .pc_load_o(a_pcl), .pc_target_o(a_tgt),
        .sram_owner_o(a_own), .mem_done_o(a_done), .stall_cnt_o(a_cnt)
    );

    pipe_ctrl #(.MEM_LAT(LAT_B), .CNT_W(CW_B)) u_dut_b (
        .clk(clk), .rst(rst), .mem_req_i(mem_req), .stallreq_id_i(stallreq_id),
        .branch_flag_i(branch_flag), .branch_addr_i(branch_addr),
        .flush_req_i(flush_req), .flush_addr_i(flush_addr),
        .stall_o(b_stall), .flush_o(b_flush), .pc_load_o(b_pcl), .pc_target_o(b_tgt),
        .sram_owner_o(b_own), .mem_done_o(b_done), .stall_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one access takes lat cycles of stall, the last one is "done";
    // a store's refetch fires on the first free RUN cycle after its access.
    task automatic model(input int lat, input int cmax, input mst_t s,
                         output exp_t e, output mst_t n);
        e = '{stall: 6'b0, flush: 1'b0, pcl: 1'b0, tgt: 16'h0, own: 1'b0, done: 1'b0, cnt: s.cnt};
        n = s;
        if (rst) begin
            n = '{rem: 0, fp: 1'b0, pa: 16'h0, cnt: 0};
        end else begin
            if (s.rem > 0) begin
                e.own = 1'b1;
                if (s.rem == 1) begin
                    e.stall = 6'b001111;
                    e.done  = 1'b1;
                end else begin
                    e.stall = 6'b011111;
                end
                n.rem = s.rem - 1;
            end else if (s.fp) begin
                e.flush = 1'b1;
                e.pcl   = 1'b1;
                e.tgt   = s.pa;
                n.fp    = 1'b0;
            end else if (mem_req) begin
                e.own = 1'b1;
                if (lat == 1) begin
                    e.stall = 6'b001111;
                    e.done  = 1'b1;
                end else begin
                    e.stall = 6'b011111;
                    n.rem   = lat - 1;
                end
            end else if (stallreq_id) begin
                e.stall = 6'b000111;
            end else if (branch_flag) begin
                e.pcl = 1'b1;
                e.tgt = branch_addr;
            end
            if (e.done && flush_req) begin
                n.fp = 1'b1;
                n.pa = flush_addr;
            end
            if (e.stall[0] && s.cnt < cmax)
                n.cnt = s.cnt + 1;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit m, input bit s, input bit b,
                       input logic [15:0] ba, input bit f, input logic [15:0] fa);
        exp_t e;
        mst_t n;
        @(posedge clk);
        #1;
        rst = r; mem_req = m; stallreq_id = s; branch_flag = b;
        branch_addr = ba; flush_req = f; flush_addr = fa;
        model(LAT_A, (1 << CW_A) - 1, sa, e, n);
        qa.push_back(e);
        sa = n;
        model(LAT_B, (1 << CW_B) - 1, sb, e, n);
        qb.push_back(e);
        sb = n;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    // Monitor: every cycle presents a full output set; compare at mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("A.stall", 32'(a_stall), 32'(e.stall));
                cmp("A.flush", 32'(a_flush), 32'(e.flush));
                cmp("A.pc_load", 32'(a_pcl), 32'(e.pcl));
                cmp("A.pc_target", 32'(a_tgt), 32'(e.tgt));
                cmp("A.sram_owner", 32'(a_own), 32'(e.own));
                cmp("A.mem_done", 32'(a_done), 32'(e.done));
                cmp("A.stall_cnt", 32'(a_cnt), 32'(e.cnt));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("B.stall", 32'(b_stall), 32'(e.stall));
                cmp("B.flush", 32'(b_flush), 32'(e.flush));
                cmp("B.pc_load", 32'(b_pcl), 32'(e.pcl));
                cmp("B.pc_target", 32'(b_tgt), 32'(e.tgt));
                cmp("B.sram_owner", 32'(b_own), 32'(e.own));
                cmp("B.mem_done", 32'(b_done), 32'(e.done));
                cmp("B.stall_cnt", 32'(b_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b1; mem_req = 0; stallreq_id = 0; branch_flag = 0;
        branch_addr = 16'h0; flush_req = 0; flush_addr = 16'h0;
        sa = '{rem: 0, fp: 1'b0, pa: 16'h0, cnt: 0};
        sb = sa;
        repeat (2) @(posedge clk);

        cyc(1, 0, 0, 0, 16'h0, 0, 16'h0);
        idle(5);
        // Load-use stall for a single cycle
        cyc(0, 0, 1, 0, 16'h0, 0, 16'h0);
        idle(2);
        // Access held until done
        for (int i = 0; i < LAT_A; i++) cyc(0, 1, 0, 0, 16'h0, 0, 16'h0);
        idle(2);
        // Store into instruction region
        for (int i = 0; i < LAT_A; i++) cyc(0, 1, 0, 0, 16'h0, 1, 16'h4010);
        idle(3);
        // Branch held through an access, then immediate branch
        cyc(0, 1, 0, 1, 16'h0020, 0, 16'h0);
        for (int i = 0; i < LAT_A; i++) cyc(0, 0, 0, 1, 16'h0020, 0, 16'h0);
        idle(1);
        cyc(0, 0, 0, 1, 16'h0077, 0, 16'h0);
        idle(1);
        // Reset mid-access with a flush request outstanding
        cyc(0, 1, 0, 0, 16'h0, 1, 16'h1234);
        cyc(1, 0, 0, 0, 16'h0, 1, 16'h1234);
        idle(3);
        // Saturate the narrow counter
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 16'h0, 0, 16'h0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 30),
                16'($urandom),
                ($urandom_range(0, 99) < 40),
                16'($urandom));
        end
        idle(2);

        wait_cnt = 0;
        while ((qa.size() > 0 || qb.size() > 0) && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", qa.size() + qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
